// File: rtl/irq_pend_ctrl8_if.sv
// rtl/irq_pend_ctrl8_if.sv - request/handshake bundle for the eight-line interrupt front end
//
// Purpose: groups the request, mask and handshake signals exchanged between an
//          interrupt source/consumer (master) and irq_pend_ctrl8 (slave).
// Signals:
//   req[7:0]     request lines, a 0->1 transition is an event
//   mask[7:0]    1 = line excluded from selection (pending still sets)
//   ack          one-cycle acknowledge, honoured only while irq is high
//   eoi          one-cycle end-of-service, honoured only while busy is high
//   irq          interrupt asserted, waiting for ack
//   vec[2:0]     index of the line being asserted / serviced
//   busy         interrupt in service, waiting for eoi
//   pending[7:0] pending event register
interface irq_pend_ctrl8_if;
  logic [7:0] req;
  logic [7:0] mask;
  logic       ack;
  logic       eoi;
  logic       irq;
  logic [2:0] vec;
  logic       busy;
  logic [7:0] pending;

  modport master (
    output req, mask, ack, eoi,
    input  irq, vec, busy, pending
  );

  modport slave (
    input  req, mask, ack, eoi,
    output irq, vec, busy, pending
  );
endinterface

// File: rtl/irq_pend_ctrl8.sv
// rtl/irq_pend_ctrl8.sv - eight-line edge-latched interrupt pending/priority/handshake controller
//
// Purpose: latches rising edges of eight request lines into a pending register,
//          picks the highest unmasked pending line (bit 7 highest) and runs one
//          outstanding interrupt through assert / acknowledge / end-of-service.
// Ports:
//   clk  single clock, rising edge
//   rst  synchronous active-high reset
//   bus  irq_pend_ctrl8_if.slave: req, mask, ack, eoi in; irq, vec, busy, pending out
module irq_pend_ctrl8 (
  input  logic            clk,
  input  logic            rst,
  irq_pend_ctrl8_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] req_q, req_d;
  logic [7:0] pending_q, pending_d;
  logic [2:0] vec_q, vec_d;
  logic       irq_q, irq_d;
  logic       busy_q, busy_d;

  logic [7:0] req_edge;
  logic [7:0] eligible;
  logic [2:0] select;
  logic [7:0] clr_vec;

  assign req_edge = bus.req & ~req_q;
  assign eligible = pending_q & ~bus.mask;
  assign clr_vec  = 8'h01 << vec_q;

  // Ascending scan so the highest set bit overwrites lower ones.
  always_comb begin
    select = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (eligible[i]) begin
        select = i[2:0];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    req_d     = bus.req;
    pending_d = pending_q | req_edge;
    vec_d     = vec_q;
    irq_d     = irq_q;
    busy_d    = busy_q;

    case (state_q)
      ST_IDLE: begin
        if (eligible != 8'h00) begin
          state_d = ST_ASSERT;
          vec_d   = select;
          irq_d   = 1'b1;
        end
      end
      ST_ASSERT: begin
        // ack wins over a simultaneous eoi; a new edge on the serviced
        // line in the same cycle re-sets the bit it clears.
        if (bus.ack) begin
          state_d   = ST_SERVICE;
          pending_d = (pending_q & ~clr_vec) | req_edge;
          irq_d     = 1'b0;
          busy_d    = 1'b1;
        end
      end
      ST_SERVICE: begin
        if (bus.eoi) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        irq_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      req_q     <= 8'h00;
      pending_q <= 8'h00;
      vec_q     <= 3'd0;
      irq_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      pending_q <= pending_d;
      vec_q     <= vec_d;
      irq_q     <= irq_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.irq     = irq_q;
  assign bus.vec     = vec_q;
  assign bus.busy    = busy_q;
  assign bus.pending = pending_q;

endmodule

// File: tb/tb_irq_pend_ctrl8.sv
// tb/tb_irq_pend_ctrl8.sv - scoreboard bench for irq_pend_ctrl8
module tb_irq_pend_ctrl8;

  localparam int EV_IRQ_RISE  = 0;
  localparam int EV_BUSY_RISE = 1;
  localparam int EV_BUSY_FALL = 2;

  typedef struct {
    int         evt;
    logic [2:0] vec;
    logic [7:0] pend;
  } exp_t;

  logic clk;
  logic rst;
  irq_pend_ctrl8_if bus ();

  irq_pend_ctrl8 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  exp_t sbq[$];
  int   n_checks;
  int   n_errors;
  bit   done;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int evt, input logic [2:0] v, input logic [7:0] p);
    exp_t e;
    e.evt  = evt;
    e.vec  = v;
    e.pend = p;
    sbq.push_back(e);
  endtask

  task automatic do_ack(input logic [2:0] v, input logic [7:0] p_after);
    push(EV_BUSY_RISE, v, p_after);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    chk("ack_busy", {31'd0, bus.busy}, 32'd1);
    chk("ack_pending", {24'd0, bus.pending}, {24'd0, p_after});
  endtask

  task automatic do_eoi(input logic [2:0] v, input logic [7:0] p);
    push(EV_BUSY_FALL, v, p);
    bus.eoi = 1'b1;
    tick();
    bus.eoi = 1'b0;
    chk("eoi_busy", {31'd0, bus.busy}, 32'd0);
    chk("eoi_irq", {31'd0, bus.irq}, 32'd0);
  endtask

  // Monitor: each irq rise, busy rise or busy fall pops one expectation.
  initial begin
    logic prev_irq;
    logic prev_busy;
    int   ev;
    exp_t e;
    prev_irq  = 1'b0;
    prev_busy = 1'b0;
    while (!done) begin
      @(negedge clk);
      ev = -1;
      if (bus.irq === 1'b1 && prev_irq === 1'b0)        ev = EV_IRQ_RISE;
      else if (bus.busy === 1'b1 && prev_busy === 1'b0) ev = EV_BUSY_RISE;
      else if (bus.busy === 1'b0 && prev_busy === 1'b1) ev = EV_BUSY_FALL;
      if (ev >= 0) begin
        if (sbq.size() == 0) begin
          chk("sb_unexpected_event", ev, 32'hffff);
        end else begin
          e = sbq.pop_front();
          chk("sb_event", ev, e.evt);
          chk("sb_vec", {29'd0, bus.vec}, {29'd0, e.vec});
          chk("sb_pending", {24'd0, bus.pending}, {24'd0, e.pend});
        end
      end
      prev_irq  = bus.irq;
      prev_busy = bus.busy;
    end
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    done     = 1'b0;
    rst      = 1'b1;
    bus.req  = 8'h00;
    bus.mask = 8'h00;
    bus.ack  = 1'b0;
    bus.eoi  = 1'b0;
    repeat (3) tick();
    rst = 1'b0;

    // Quiet after reset
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_idle", {19'd0, bus.irq, bus.busy, bus.vec, bus.pending}, 32'd0);
    end

    // Two lines at once, highest first, then the lower one
    bus.req = 8'h24;
    tick();
    chk("edge_pending", {24'd0, bus.pending}, 32'h24);
    chk("edge_no_irq_yet", {31'd0, bus.irq}, 32'd0);
    push(EV_IRQ_RISE, 3'd5, 8'h24);
    tick();
    chk("irq_latency", {31'd0, bus.irq}, 32'd1);
    do_ack(3'd5, 8'h04);
    do_eoi(3'd5, 8'h04);
    push(EV_IRQ_RISE, 3'd2, 8'h04);
    tick();
    chk("second_irq_vec", {28'd0, bus.irq, bus.vec}, {28'd0, 4'b1010});
    do_ack(3'd2, 8'h00);
    do_eoi(3'd2, 8'h00);

    // Masked line stays pending until unmasked in IDLE
    bus.req = 8'h00;
    tick();
    bus.mask = 8'h80;
    bus.req  = 8'h82;
    tick();
    chk("mask_pending", {24'd0, bus.pending}, 32'h82);
    push(EV_IRQ_RISE, 3'd1, 8'h82);
    tick();
    do_ack(3'd1, 8'h80);
    do_eoi(3'd1, 8'h80);
    tick();
    tick();
    chk("masked_no_irq", {31'd0, bus.irq}, 32'd0);
    chk("masked_pending_held", {24'd0, bus.pending}, 32'h80);
    bus.mask = 8'h00;
    push(EV_IRQ_RISE, 3'd7, 8'h80);
    tick();
    chk("unmask_irq", {31'd0, bus.irq}, 32'd1);
    do_ack(3'd7, 8'h00);
    do_eoi(3'd7, 8'h00);

    // vec frozen in ASSERT despite higher arrival and mask change
    bus.req = 8'h00;
    tick();
    bus.req = 8'h08;
    tick();
    push(EV_IRQ_RISE, 3'd3, 8'h08);
    tick();
    bus.req  = 8'h48;
    bus.mask = 8'h08;
    tick();
    chk("frozen_irq_vec", {28'd0, bus.irq, bus.vec}, {28'd0, 4'b1011});
    chk("frozen_pending", {24'd0, bus.pending}, 32'h48);
    tick();
    chk("frozen_irq_vec2", {28'd0, bus.irq, bus.vec}, {28'd0, 4'b1011});
    do_ack(3'd3, 8'h40);
    do_eoi(3'd3, 8'h40);
    push(EV_IRQ_RISE, 3'd6, 8'h40);
    tick();
    do_ack(3'd6, 8'h00);
    do_eoi(3'd6, 8'h00);
    bus.mask = 8'h00;

    // ack/eoi ignored while idle
    bus.req = 8'h00;
    tick();
    bus.ack = 1'b1;
    bus.eoi = 1'b1;
    tick();
    bus.ack = 1'b0;
    bus.eoi = 1'b0;
    chk("idle_ack_ignored", {22'd0, bus.irq, bus.busy, bus.pending}, 32'd0);

    // Set wins over the ack clear on the same line
    bus.req = 8'h10;
    tick();
    push(EV_IRQ_RISE, 3'd4, 8'h10);
    tick();
    bus.req = 8'h00;
    tick();
    bus.req = 8'h10;
    do_ack(3'd4, 8'h10);
    do_eoi(3'd4, 8'h10);
    push(EV_IRQ_RISE, 3'd4, 8'h10);
    tick();
    chk("reassert_vec", {28'd0, bus.irq, bus.vec}, {28'd0, 4'b1100});
    do_ack(3'd4, 8'h00);
    do_eoi(3'd4, 8'h00);

    // Reset during SERVICE, req held through reset
    bus.req = 8'h00;
    tick();
    bus.req = 8'h31;
    tick();
    push(EV_IRQ_RISE, 3'd5, 8'h31);
    tick();
    do_ack(3'd5, 8'h11);
    push(EV_BUSY_FALL, 3'd0, 8'h00);
    push(EV_IRQ_RISE, 3'd5, 8'h31);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_outputs", {19'd0, bus.irq, bus.busy, bus.vec, bus.pending}, 32'd0);
    tick();
    chk("post_rst_edge", {23'd0, bus.irq, bus.pending}, 32'h031);
    tick();
    chk("post_rst_irq", {28'd0, bus.irq, bus.vec}, {28'd0, 4'b1101});

    tick();
    tick();
    done = 1'b1;
    tick();
    chk("sb_drained", sbq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
